// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb with Moore datapath strobes.
// Define CTRL_TRAP_EN to halt in a sticky TRAP state on illegal instructions (default: treat as NOP).
module ctrl_fsm #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic [15:0] pc,
  output logic        imem_req,
  output logic [2:0]  opcode,
  output logic [3:0]  func,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic [2:0]  rd,
  output logic [15:0] imm,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        reg_dst_rd,
  output logic        mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] instr_retired,
  output logic        illegal,
  output logic        trap
);

`ifdef CTRL_TRAP_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
`endif

  state_t      state;
  logic [15:0] ir;
  logic        legal;
  logic        is_st;
  logic        is_ld;

  assign opcode = ir[15:13];
  assign rs     = ir[12:10];
  assign rt     = ir[9:7];
  assign rd     = ir[6:4];
  assign func   = ir[3:0];
  assign imm    = {{9{ir[6]}}, ir[6:0]};
  assign is_st  = (opcode == 3'b011);
  assign is_ld  = (opcode == 3'b100);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      3'b000:                      legal = (func[3] == 1'b0) && (func != 4'b0010);
      3'b001, 3'b010, 3'b011, 3'b100: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= PC_RESET;
      ir            <= '0;
      instr_retired <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            ir    <= instr;
            pc    <= pc + 16'd1;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (legal) begin
            state <= EXEC;
          end else begin
`ifdef CTRL_TRAP_EN
            state <= TRAP;
`else
            state <= FETCH;
`endif
          end
        end
        EXEC: begin
          if (is_st || is_ld) state <= MEM;
          else                state <= WB;
        end
        MEM: begin
          if (dmem_ready) begin
            if (is_st) begin
              instr_retired <= instr_retired + 16'd1;
              state         <= FETCH;
            end else begin
              state <= WB;
            end
          end
        end
        WB: begin
          instr_retired <= instr_retired + 16'd1;
          state         <= FETCH;
        end
`ifdef CTRL_TRAP_EN
        TRAP:    state <= TRAP;
`endif
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are pure state/IR decode, but rst masks them in the same cycle it is raised.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:  imem_req    = 1'b1;
        DECODE: illegal     = !legal;
        EXEC:   alu_src_imm = (opcode != 3'b000) && (opcode <= 3'b100);
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_st;
        end
        WB: begin
          reg_we     = 1'b1;
          reg_dst_rd = (opcode == 3'b000);
          mem_to_reg = is_ld;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_TRAP_EN
  assign trap = (state == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: per-cycle stimulus and expected outputs queued, then popped and compared.
// Second instance uses PC_RESET=16'hFFFF to observe program-counter wrap.
module tb_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;

  logic [15:0] pc, imm, instr_retired;
  logic [2:0]  opcode, rs, rt, rd;
  logic [3:0]  func;
  logic        imem_req, alu_src_imm, reg_we, reg_dst_rd, mem_to_reg, dmem_req, dmem_we, illegal, trap;

  logic [15:0] pc2, imm2, instr_retired2;
  logic [2:0]  opcode2, rs2, rt2, rd2;
  logic [3:0]  func2;
  logic        imem_req2, alu_src_imm2, reg_we2, reg_dst_rd2, mem_to_reg2, dmem_req2, dmem_we2, illegal2, trap2;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc(pc), .imem_req(imem_req), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .alu_src_imm(alu_src_imm), .reg_we(reg_we), .reg_dst_rd(reg_dst_rd),
    .mem_to_reg(mem_to_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .instr_retired(instr_retired), .illegal(illegal), .trap(trap)
  );

  ctrl_fsm #(.PC_RESET(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc(pc2), .imem_req(imem_req2), .opcode(opcode2), .func(func2), .rs(rs2), .rt(rt2), .rd(rd2),
    .imm(imm2), .alu_src_imm(alu_src_imm2), .reg_we(reg_we2), .reg_dst_rd(reg_dst_rd2),
    .mem_to_reg(mem_to_reg2), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
    .instr_retired(instr_retired2), .illegal(illegal2), .trap(trap2)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] S_NONE = 9'h000;
  localparam logic [8:0] S_IM   = 9'h100;
  localparam logic [8:0] S_DR   = 9'h080;
  localparam logic [8:0] S_DW   = 9'h040;
  localparam logic [8:0] S_WE   = 9'h020;
  localparam logic [8:0] S_RD   = 9'h010;
  localparam logic [8:0] S_M2R  = 9'h008;
  localparam logic [8:0] S_ASRC = 9'h004;
  localparam logic [8:0] S_ILL  = 9'h002;
  localparam logic [8:0] S_TRP  = 9'h001;

  typedef struct {
    logic        rst;
    logic        irdy;
    logic        drdy;
    logic [15:0] instr;
    logic        chk;
    logic [40:0] exp;
    logic        chkf;
    logic [31:0] fld;
    logic        chk2;
    logic [15:0] pc2;
  } step_t;

  step_t sb[$];
  step_t s;
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;

  function automatic logic [40:0] obs();
    return {imem_req, dmem_req, dmem_we, reg_we, reg_dst_rd, mem_to_reg, alu_src_imm,
            illegal, trap, pc, instr_retired};
  endfunction

  function automatic logic [31:0] obs_fld();
    return {opcode, func, rs, rt, rd, imm};
  endfunction

  function automatic void push(input logic r, input logic ir_, input logic dr, input logic [15:0] in,
                               input logic c, input logic [8:0] strb, input logic [15:0] epc,
                               input logic [15:0] eret);
    step_t e;
    e.rst = r; e.irdy = ir_; e.drdy = dr; e.instr = in; e.chk = c;
    e.exp = {strb, epc, eret};
    e.chkf = 1'b0; e.fld = '0; e.chk2 = 1'b0; e.pc2 = '0;
    sb.push_back(e);
  endfunction

  function automatic void add_fld(input logic [2:0] op, input logic [3:0] fn, input logic [2:0] a,
                                  input logic [2:0] b, input logic [2:0] c, input logic [15:0] im);
    sb[sb.size()-1].chkf = 1'b1;
    sb[sb.size()-1].fld  = {op, fn, a, b, c, im};
  endfunction

  function automatic void add_pc2(input logic [15:0] v);
    sb[sb.size()-1].chk2 = 1'b1;
    sb[sb.size()-1].pc2  = v;
  endfunction

  task automatic test_reset();
    push(1, 0, 0, 16'h0000, 0, S_NONE, 0, 0);
    push(1, 0, 0, 16'h0000, 1, S_NONE, 0, 0); add_pc2(16'hFFFF);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL reset.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      if (s.chk2) begin
        n_cmp++;
        if (pc2 !== s.pc2) begin n_err++; $display("FAIL reset.pc2 cyc%0d got %h required %h", cyc, pc2, s.pc2); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    push(0, 1, 1, 16'h0001, 1, S_IM, 0, 0);
    push(0, 1, 1, 16'h0001, 1, S_NONE, 1, 0); add_fld(3'd0, 4'd1, 3'd0, 3'd0, 3'd0, 16'h0001);
    push(0, 1, 1, 16'h0001, 1, S_NONE, 1, 0);
    push(0, 1, 1, 16'h0001, 1, S_WE | S_RD, 1, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL rtype.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      if (s.chkf) begin
        n_cmp++;
        if (obs_fld() !== s.fld) begin n_err++; $display("FAIL rtype.fields cyc%0d got %h required %h", cyc, obs_fld(), s.fld); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_wait();
    push(0, 0, 0, 16'hE000, 1, S_IM, 1, 1);
    push(0, 0, 0, 16'hE000, 1, S_IM, 1, 1);
    push(0, 1, 0, 16'h29E5, 1, S_IM, 1, 1);
    push(0, 0, 0, 16'hE000, 1, S_NONE, 2, 1); add_fld(3'd1, 4'd5, 3'd2, 3'd3, 3'd6, 16'hFFE5);
    push(0, 1, 1, 16'hE000, 1, S_ASRC, 2, 1); add_fld(3'd1, 4'd5, 3'd2, 3'd3, 3'd6, 16'hFFE5);
    push(0, 1, 1, 16'hE000, 1, S_WE, 2, 1);   add_fld(3'd1, 4'd5, 3'd2, 3'd3, 3'd6, 16'hFFE5);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL addi.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      if (s.chkf) begin
        n_cmp++;
        if (obs_fld() !== s.fld) begin n_err++; $display("FAIL addi.fields cyc%0d got %h required %h", cyc, obs_fld(), s.fld); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ld_wait();
    push(0, 1, 0, 16'h8000, 1, S_IM, 2, 2);
    push(0, 0, 1, 16'h0000, 1, S_NONE, 3, 2);
    push(0, 0, 1, 16'h0000, 1, S_ASRC, 3, 2);
    push(0, 1, 0, 16'h0000, 1, S_DR, 3, 2); add_fld(3'd4, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    push(0, 1, 0, 16'h0000, 1, S_DR, 3, 2);
    push(0, 1, 0, 16'h0000, 1, S_DR, 3, 2);
    push(0, 1, 1, 16'h0000, 1, S_DR, 3, 2);
    push(0, 1, 1, 16'h0000, 1, S_WE | S_M2R, 3, 2); add_fld(3'd4, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL ld.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      if (s.chkf) begin
        n_cmp++;
        if (obs_fld() !== s.fld) begin n_err++; $display("FAIL ld.fields cyc%0d got %h required %h", cyc, obs_fld(), s.fld); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_st();
    push(0, 1, 1, 16'h6000, 1, S_IM, 3, 3);
    push(0, 1, 1, 16'h6000, 1, S_NONE, 4, 3);
    push(0, 1, 1, 16'h6000, 1, S_ASRC, 4, 3);
    push(0, 1, 1, 16'h6000, 1, S_DR | S_DW, 4, 3);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL st.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    push(0, 1, 1, 16'hE000, 1, S_IM, 4, 4);
    push(0, 1, 1, 16'h0002, 1, S_ILL, 5, 4);
`ifdef CTRL_TRAP_EN
    push(0, 1, 1, 16'h0002, 1, S_TRP, 5, 4);
    push(0, 1, 1, 16'h0002, 1, S_TRP, 5, 4);
`else
    push(0, 1, 1, 16'h0002, 1, S_IM, 5, 4);
    push(0, 0, 1, 16'h0002, 1, S_ILL, 6, 4);
    push(0, 0, 1, 16'h0002, 1, S_IM, 6, 4);
`endif
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL illegal.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pc_wrap();
    push(1, 0, 0, 16'h0001, 0, S_NONE, 0, 0);
    push(1, 0, 0, 16'h0001, 1, S_NONE, 0, 0); add_pc2(16'hFFFF);
    push(0, 1, 1, 16'h0001, 1, S_IM, 0, 0);   add_pc2(16'hFFFF);
    push(0, 1, 1, 16'h0001, 1, S_NONE, 1, 0); add_pc2(16'h0000);
    push(0, 1, 1, 16'h0001, 1, S_NONE, 1, 0);
    push(0, 1, 1, 16'h0001, 1, S_WE | S_RD, 1, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL wrap.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      if (s.chk2) begin
        n_cmp++;
        if (pc2 !== s.pc2) begin n_err++; $display("FAIL wrap.pc2 cyc%0d got %h required %h", cyc, pc2, s.pc2); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    push(1, 1, 1, 16'h8000, 1, S_NONE, 1, 1);
    push(1, 1, 1, 16'h8000, 1, S_NONE, 0, 0);
    push(0, 1, 0, 16'h8000, 1, S_IM, 0, 0);
    push(0, 0, 0, 16'h8000, 1, S_NONE, 1, 0);
    push(0, 0, 0, 16'h8000, 1, S_ASRC, 1, 0);
    push(0, 0, 0, 16'h8000, 1, S_DR, 1, 0);
    push(1, 0, 1, 16'h8000, 1, S_NONE, 1, 0);
    push(0, 0, 1, 16'h8000, 1, S_IM, 0, 0);
    push(0, 0, 1, 16'h8000, 1, S_IM, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL rst_mem.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wb();
    push(0, 1, 1, 16'h0005, 1, S_IM, 0, 0);
    push(0, 1, 1, 16'h0005, 1, S_NONE, 1, 0);
    push(0, 1, 1, 16'h0005, 1, S_NONE, 1, 0);
    push(1, 1, 1, 16'h0005, 1, S_NONE, 1, 0);
    push(0, 0, 1, 16'h0005, 1, S_IM, 0, 0);
    push(0, 0, 1, 16'h0005, 1, S_IM, 0, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front(); cyc++;
      rst = s.rst; imem_ready = s.irdy; dmem_ready = s.drdy; instr = s.instr;
      @(negedge clk);
      if (s.chk) begin
        n_cmp++;
        if (obs() !== s.exp) begin n_err++; $display("FAIL rst_wb.ctl cyc%0d got %h required %h", cyc, obs(), s.exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_addi_wait();
    test_ld_wait();
    test_st();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_mem();
    test_reset_mid_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
